// File: rtl/grover_iteration_seq_if.sv
// Control and readout bundle for the serial Grover search engine.
// The master side starts a search and selects the amplitude to read.
// The slave side returns amplitude data and search status.
interface grover_iteration_seq_if #(
    parameter int QBITS  = 3,
    parameter int W      = 8,
    parameter int ITER_W = 4
);
    logic                    start;
    logic [QBITS-1:0]        target_search;
    logic [ITER_W-1:0]       num_iter;
    logic [QBITS-1:0]        rd_addr;
    logic signed [W-1:0]     rd_data;
    logic                    busy;
    logic                    done;

    modport master (
        output start, target_search, num_iter, rd_addr,
        input  rd_data, busy, done
    );

    modport slave (
        input  start, target_search, num_iter, rd_addr,
        output rd_data, busy, done
    );
endinterface

// File: rtl/grover_iteration_seq.sv
// Serial Grover search engine over N = 2^QBITS signed amplitudes.
// Each iteration has three phases:
//   1. Oracle: phase-inverts the marked index (N cycles).
//   2. Mean: derives the mean from the oracle-phase sum (1 cycle).
//   3. Diffusion: reflects every amplitude about that mean (N cycles).
// Every write is saturated to the signed W-bit range.
module grover_iteration_seq #(
    parameter int QBITS    = 3,
    parameter int W        = 8,
    parameter int ITER_W   = 4,
    parameter int AMP_INIT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    grover_iteration_seq_if.slave   bus
);
    localparam int N  = 1 << QBITS;
    localparam int SW = W + QBITS;   // the sum of N W-bit values never overflows this width
    localparam int XW = W + 3;       // headroom for negation and for 2*mean - a

    localparam logic signed [W-1:0]  AMP_INIT_W = W'(AMP_INIT);
    localparam logic signed [XW-1:0] MAX_X      = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] MIN_X      = {4'b1111, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ORACLE,
        S_MEAN,
        S_DIFF,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [QBITS-1:0]        target_q;
    logic [ITER_W-1:0]       k_q;
    logic [ITER_W-1:0]       iter_q;
    logic [QBITS-1:0]        idx_q;
    logic signed [SW-1:0]    sum_q;
    logic signed [W+1:0]     mean2_q;
    logic                    busy_q;
    logic                    done_q;
    logic signed [W-1:0]     amp_q [N];

    logic signed [W-1:0]     cur_amp;
    logic signed [XW-1:0]    cur_x;
    logic signed [XW-1:0]    neg_x;
    logic signed [XW-1:0]    mean2_x;
    logic signed [XW-1:0]    diff_x;
    logic signed [W-1:0]     wr_val_d;
    logic signed [SW-1:0]    sum_ext;
    logic signed [SW-1:0]    mean_full;
    logic [ITER_W-1:0]       iter_d;
    logic [N-1:0]            amp_we;

    // Clamp a widened intermediate to the signed W-bit range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [XW-1:0] v);
        if (v > MAX_X) begin
            return MAX_X[W-1:0];
        end else if (v < MIN_X) begin
            return MIN_X[W-1:0];
        end else begin
            return v[W-1:0];
        end
    endfunction

    // Datapath: compute the value written back to the amplitude at idx_q.
    always_comb begin
        cur_amp   = amp_q[idx_q];
        cur_x     = {{3{cur_amp[W-1]}}, cur_amp};
        neg_x     = -cur_x;
        mean2_x   = {mean2_q[W+1], mean2_q};
        diff_x    = mean2_x - cur_x;
        wr_val_d  = sat_w(diff_x);
        if (state_q == S_ORACLE) begin
            wr_val_d = (idx_q == target_q) ? sat_w(neg_x) : cur_amp;
        end
        sum_ext   = {{QBITS{wr_val_d[W-1]}}, wr_val_d};
        mean_full = sum_q >>> QBITS;   // arithmetic shift gives floor division
        iter_d    = iter_q + ITER_W'(1);
    end

    // One write enable per amplitude for the serial oracle and diffusion sweeps.
    for (genvar gi = 0; gi < N; gi++) begin : g_we
        assign amp_we[gi] = ((state_q == S_ORACLE) || (state_q == S_DIFF))
                            && (idx_q == QBITS'(gi));
    end

    // Amplitude register file: bulk load on reset or INIT, otherwise one indexed write.
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_INIT)) begin
            for (int i = 0; i < N; i++) begin
                amp_q[i] <= AMP_INIT_W;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (amp_we[i]) begin
                    amp_q[i] <= wr_val_d;
                end
            end
        end
    end

    // Control FSM with registered busy/done and the oracle sum / mean registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            k_q      <= '0;
            iter_q   <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            mean2_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        target_q <= bus.target_search;
                        k_q      <= bus.num_iter;
                        iter_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_INIT;
                    end
                end
                S_INIT: begin
                    idx_q <= '0;
                    sum_q <= '0;
                    if (k_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_ORACLE;
                    end
                end
                S_ORACLE: begin
                    sum_q <= sum_q + sum_ext;
                    idx_q <= idx_q + QBITS'(1);
                    if (idx_q == QBITS'(N - 1)) begin
                        state_q <= S_MEAN;
                    end
                end
                S_MEAN: begin
                    mean2_q <= {mean_full[W:0], 1'b0};
                    state_q <= S_DIFF;
                end
                S_DIFF: begin
                    idx_q <= idx_q + QBITS'(1);
                    if (idx_q == QBITS'(N - 1)) begin
                        iter_q <= iter_d;
                        sum_q  <= '0;
                        if (iter_d == k_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ORACLE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data = amp_q[bus.rd_addr];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_grover_iteration_seq.sv
// Scoreboard bench for grover_iteration_seq.
// Two instances share the clock: one with AMP_INIT=32 and one with AMP_INIT=-128.
// The stimulus process pushes model predictions into a queue.
// A monitor pops a prediction on each done pulse and checks timing, busy length and all amplitudes.
module tb_grover_iteration_seq;
    localparam int QB = 3;
    localparam int W  = 8;
    localparam int IW = 4;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    int   cyc   = 0;
    logic rst_d = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    logic [1:0]    start_v = '0;
    logic [QB-1:0] tgt     = '0;
    logic [IW-1:0] kk      = '0;
    logic [QB-1:0] rd_addr = '0;

    grover_iteration_seq_if #(.QBITS(QB), .W(W), .ITER_W(IW)) bus0 ();
    grover_iteration_seq_if #(.QBITS(QB), .W(W), .ITER_W(IW)) bus1 ();

    assign bus0.start         = start_v[0];
    assign bus0.target_search = tgt;
    assign bus0.num_iter      = kk;
    assign bus0.rd_addr       = rd_addr;
    assign bus1.start         = start_v[1];
    assign bus1.target_search = tgt;
    assign bus1.num_iter      = kk;
    assign bus1.rd_addr       = rd_addr;

    grover_iteration_seq #(.QBITS(QB), .W(W), .ITER_W(IW), .AMP_INIT(32)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    grover_iteration_seq #(.QBITS(QB), .W(W), .ITER_W(IW), .AMP_INIT(-128)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          dut;
        int          k;
        int          tg;
        int          c0;
        logic [63:0] amps;
    } exp_t;
    exp_t exp_q[$];

    function automatic int clampw(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference model: plain integer Grover iteration, floor mean, clamped writes.
    function automatic logic [63:0] model(input int init, input int t, input int k);
        int a[N];
        int sum;
        int mean;
        logic [63:0] r;
        for (int i = 0; i < N; i++) a[i] = init;
        for (int it = 0; it < k; it++) begin
            a[t] = clampw(-a[t]);
            sum = 0;
            for (int i = 0; i < N; i++) sum += a[i];
            mean = (sum >= 0) ? (sum / N) : -((-sum + N - 1) / N);
            for (int i = 0; i < N; i++) a[i] = clampw(2 * mean - a[i]);
        end
        r = '0;
        for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(a[i]);
        return r;
    endfunction

    function automatic int init_of(input int d);
        return (d == 1) ? -128 : 32;
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Pulse start for one instance and queue the predicted outcome.
    task automatic run(input int d, input int t, input int k);
        exp_t e;
        @(negedge clk);
        tgt        = QB'(t);
        kk         = IW'(k);
        start_v[d] = 1'b1;
        e.dut  = d;
        e.k    = k;
        e.tg   = t;
        e.c0   = cyc + 1;
        e.amps = model(init_of(d), t, k);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_v = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: reset-state checks and scoreboard comparison on each done pulse.
    initial begin : mon
        int   bcnt [2];
        logic pd   [2];
        logic dn;
        logic bz;
        logic [7:0] got;
        exp_t e;
        bcnt[0] = 0; bcnt[1] = 0;
        pd[0] = 1'b0; pd[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_d) begin
                check_int("rst_busy0", int'(bus0.busy), 0);
                check_int("rst_done0", int'(bus0.done), 0);
                check_int("rst_busy1", int'(bus1.busy), 0);
                check_int("rst_done1", int'(bus1.done), 0);
                for (int a = 0; a < N; a++) begin
                    rd_addr = QB'(a);
                    #1;
                    check_int($sformatf("rst_amp0[%0d]", a), int'($signed(bus0.rd_data)), 32);
                    check_int($sformatf("rst_amp1[%0d]", a), int'($signed(bus1.rd_data)), -128);
                end
                bcnt[0] = 0; bcnt[1] = 0;
                pd[0] = 1'b0; pd[1] = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    dn = (d == 1) ? bus1.done : bus0.done;
                    bz = (d == 1) ? bus1.busy : bus0.busy;
                    if (bz) bcnt[d]++;
                    if (dn) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: dut %0d pulsed done with nothing pending", d);
                        end else begin
                            e = exp_q.pop_front();
                            check_int("done_dut", d, e.dut);
                            check_int("done_latency", cyc - e.c0, 1 + e.k * (2 * N + 1));
                            check_int("busy_cycles", bcnt[d], 1 + e.k * (2 * N + 1));
                            check_int("done_single", int'(pd[d]), 0);
                            for (int a = 0; a < N; a++) begin
                                rd_addr = QB'(a);
                                #1;
                                got = (d == 1) ? bus1.rd_data : bus0.rd_data;
                                check_int($sformatf("amp[%0d]", a), int'($signed(got)),
                                          int'($signed(e.amps[a*8 +: 8])));
                            end
                            $display("txn dut=%0d target=%0d K=%0d latency=%0d busy=%0d", d, e.tg, e.k,
                                     cyc - e.c0, bcnt[d]);
                        end
                        bcnt[d] = 0;
                    end
                    pd[d] = dn;
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized runs.
    initial begin : stim
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 3, 1); wait_drain();
        run(0, 3, 2); wait_drain();
        run(0, 3, 3); wait_drain();
        run(0, 5, 0); wait_drain();
        run(1, 0, 1); wait_drain();

        // start with another target while the oracle is running must be ignored
        run(0, 3, 1);
        repeat (3) @(negedge clk);
        tgt        = 3'd5;
        kk         = 4'd2;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_drain();

        // reset in the middle of the first diffusion sweep; no completion expected
        @(negedge clk);
        tgt        = 3'd3;
        kk         = 4'd2;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(0, 3, 1); wait_drain();

        for (int i = 0; i < 12; i++) begin
            run(int'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), int'($urandom_range(0, 5)));
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/grover_iteration_seq.md
GROVER_ITERATION_SEQ -- requirements
Module: grover_iteration_seq

Interface
REQ-001: Parameter QBITS, default 3, number of qubits; amplitude count N = 2^QBITS.
REQ-002: Parameter W, default 8, amplitude width in bits, signed two's complement.
REQ-003: Parameter ITER_W, default 4, width of the iteration-count input.
REQ-004: Parameter AMP_INIT, default 32, signed W-bit uniform-superposition value loaded into every amplitude.
REQ-005: The block SHALL use one clock; reset is synchronous and active-high.
REQ-006: clk  input  1  rising-edge clock.
REQ-007: rst  input  1  synchronous active-high reset.
REQ-008: start  input  1  request to run a search; sampled only in IDLE.
REQ-009: target_search  input  QBITS  marked index that the oracle phase-inverts.
REQ-010: num_iter  input  ITER_W  Grover iteration count K.
REQ-011: rd_addr  input  QBITS  amplitude readout index.
REQ-012: rd_data  output  W  signed amplitude at rd_addr, combinational from the register file.
REQ-013: busy  output  1  high while a search is in progress.
REQ-014: done  output  1  one-cycle completion pulse.

Function
REQ-015: The block SHALL hold N signed W-bit amplitude registers, processed serially, one index per cycle.
REQ-016: The FSM SHALL use states IDLE, INIT, ORACLE, MEAN, DIFF, DONE.
REQ-017: In IDLE, start=1 at an edge SHALL capture target_search and num_iter, clear the iteration counter, and enter INIT.
REQ-018: INIT SHALL write AMP_INIT to all N amplitudes in one cycle, then enter DONE if K=0, else ORACLE.
REQ-019: ORACLE SHALL take N cycles for idx 0..N-1, writing sat(-a[idx]) when idx equals the captured target and a[idx] unchanged otherwise.
REQ-020: ORACLE SHALL accumulate the written values into a signed sum of W+QBITS bits, cleared on ORACLE entry.
REQ-021: MEAN SHALL take 1 cycle: mean = sum arithmetically shifted right by QBITS (floor), with 2*mean held at W+2 bits.
REQ-022: DIFF SHALL take N cycles for idx 0..N-1, writing sat(2*mean - a[idx]).
REQ-023: After DIFF, the iteration counter SHALL increment; if it equals K, the FSM SHALL enter DONE, else ORACLE.
REQ-024: sat() SHALL clamp to [-2^(W-1), 2^(W-1)-1], so negating -2^(W-1) yields 2^(W-1)-1.
REQ-025: Each iteration SHALL take exactly 2N+1 cycles.
REQ-026: busy SHALL be high in INIT, ORACLE, MEAN and DIFF, and low otherwise.
REQ-027: done SHALL be high only in DONE, which lasts one cycle and then returns to IDLE.
REQ-028: Timing: with start sampled at edge t0, done SHALL be high in the cycle following edge t0+1+K*(2N+1).
REQ-029: start SHALL be ignored in every state except IDLE; target_search and num_iter changes after capture SHALL have no effect.
REQ-030: rd_data SHALL reflect the live register contents at all times, including intermediate values while busy.
REQ-031: Amplitudes SHALL persist after DONE until the next start or rst.

Reset
REQ-032: When rst is high at an edge, the block SHALL enter IDLE, set every amplitude to AMP_INIT, clear the iteration counter and sum, and drive busy=0 and done=0.
REQ-033: Reset SHALL take priority over start and over any in-progress state, including mid-ORACLE, mid-DIFF and DONE.

Verification (N=8, W=8, AMP_INIT=32 unless stated)
REQ-034: target=3, K=1 -> done at t0+19; a[3]=80, all other amplitudes=16; busy high for 18 cycles.
REQ-035: target=3, K=2 -> done at t0+36; a[3]=88, others=-8; K=3 -> a[3]=52, others=-28.
REQ-036: AMP_INIT=-128, target=0, K=1 -> the oracle saturates a[0] to 127, mean=-97; final a[0]=-128 (saturated), others=-66.
REQ-037: K=0 -> done at t0+2; all amplitudes=32; busy high for 1 cycle.
REQ-038: start pulsed during ORACLE with a different target -> ignored; result identical to REQ-034.
REQ-039: rst asserted during DIFF of iteration 1 -> next cycle busy=0, done=0, every rd_data=32; a subsequent start runs normally.
